// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: LSU has priority, and a saturating wait counter gives a starved fetch one forced grant.
// Read data returns one cycle after grant, steered by a registered tag; a losing requester sees stall and holds its request.
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 3,
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_stall,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic [1:0]    ls_func,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_stall,
  output logic          ls_valid,
  output logic [DW-1:0] ls_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          err
);

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_IF   = 2'd1,
    PEND_LS   = 2'd2
  } pend_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic       ls_rd, ls_wr, ls_req;
  logic       force_if, grant_ls, grant_if;
  pend_e      pend_q, pend_d;
  logic [3:0] wait_q, wait_d;
  logic       err_q, err_d;

  always_comb begin
    ls_rd    = (ls_func == 2'b01);
    ls_wr    = (ls_func == 2'b10);
    ls_req   = ls_rd | ls_wr;
    force_if = if_req && (wait_q == MAX_WAIT_C);
    // Reset suppresses every grant so no strobe reaches memory while rst is high.
    grant_ls = !rst && ls_req && !force_if;
    grant_if = !rst && if_req && !grant_ls;
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    if (grant_ls) begin
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
      mem_re    = ls_rd;
      mem_we    = ls_wr;
    end else if (grant_if) begin
      mem_addr  = if_addr;
      mem_re    = 1'b1;
    end
  end

  assign if_stall = !rst && if_req && !grant_if;
  assign ls_stall = !rst && ls_req && !grant_ls;

  always_comb begin
    pend_d = PEND_NONE;
    if (grant_ls && ls_rd) begin
      pend_d = PEND_LS;
    end else if (grant_if) begin
      pend_d = PEND_IF;
    end

    wait_d = wait_q;
    if (!if_req || grant_if) begin
      wait_d = 4'd0;
    end else if (if_stall && (wait_q != MAX_WAIT_C)) begin
      wait_d = wait_q + 4'd1;
    end

    err_d = err_q | (ls_func == 2'b11);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= PEND_NONE;
      wait_q <= 4'd0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  // A read granted just before reset still has its tag set during the reset cycle; mask it there.
  assign if_valid = !rst && (pend_q == PEND_IF);
  assign ls_valid = !rst && (pend_q == PEND_LS);
  assign if_rdata = mem_rdata;
  assign ls_rdata = mem_rdata;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random stimulus for mem_port_arbiter, checked against a per-cycle reference model
// with its own shadow memory; a simple 1-cycle-latency memory is modelled around the DUT.
module tb_mem_port_arbiter;
  localparam int MAX_WAIT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       if_req;
  logic [7:0] if_addr;
  logic       if_stall, if_valid;
  logic [7:0] if_rdata;
  logic [1:0] ls_func;
  logic [7:0] ls_addr, ls_wdata;
  logic       ls_stall, ls_valid;
  logic [7:0] ls_rdata;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_re, mem_we;
  logic [7:0] mem_rdata;
  logic       err;

  mem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(8), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .ls_func(ls_func), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_stall(ls_stall), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  // External memory: preload port used only during initial reset.
  logic [7:0] env_mem [256];
  logic       pl_en;
  logic [7:0] pl_addr, pl_dat;
  always @(posedge clk) begin
    if (pl_en) env_mem[pl_addr] <= pl_dat;
    else if (mem_we) env_mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= env_mem[mem_addr];
  end

  // Reference model state
  logic [7:0] ref_mem [256];
  int         errors = 0;
  int         checks = 0;
  int         losses = 0;
  bit         exp_err = 1'b0;
  int         prev_kind = 0;   // 0 none, 1 fetch read, 2 LSU read
  logic [7:0] prev_data = 8'h00;
  bit         last_if_stall = 1'b0;
  int         wr_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check this cycle's outputs, advance the model.
  task automatic step(input logic r, input logic ifq, input logic [7:0] ia,
                      input logic [1:0] f, input logic [7:0] la, input logic [7:0] wd);
    bit   lsreq, frc, e_re, e_we, e_ifst, e_lsst;
    int   gk;
    logic [7:0] e_addr, e_wdata;
    @(negedge clk);
    rst = r; if_req = ifq; if_addr = ia; ls_func = f; ls_addr = la; ls_wdata = wd;
    #1;
    lsreq = (f == 2'd1) || (f == 2'd2);
    frc   = ifq && (losses >= MAX_WAIT);
    gk = 0;
    if (!r) begin
      if (lsreq && !frc) gk = 2;
      else if (ifq)      gk = 1;
    end
    e_addr  = (gk == 2) ? la : ((gk == 1) ? ia : 8'h00);
    e_wdata = (gk == 2) ? wd : 8'h00;
    e_re    = (gk == 1) || (gk == 2 && f == 2'd1);
    e_we    = (gk == 2) && (f == 2'd2);
    e_ifst  = !r && ifq && (gk != 1);
    e_lsst  = !r && lsreq && (gk != 2);
    check("mem_addr", 32'(mem_addr), 32'(e_addr));
    check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    check("mem_re", 32'(mem_re), 32'(e_re));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("if_stall", 32'(if_stall), 32'(e_ifst));
    check("ls_stall", 32'(ls_stall), 32'(e_lsst));
    check("if_valid", 32'(if_valid), 32'(!r && prev_kind == 1));
    check("ls_valid", 32'(ls_valid), 32'(!r && prev_kind == 2));
    if (!r && prev_kind == 1) check("if_rdata", 32'(if_rdata), 32'(prev_data));
    if (!r && prev_kind == 2) check("ls_rdata", 32'(ls_rdata), 32'(prev_data));
    check("err", 32'(err), 32'(exp_err));
    if (mem_we) wr_count++;
    if (r) begin
      losses = 0; exp_err = 1'b0; prev_kind = 0; last_if_stall = 1'b0;
    end else begin
      if (ifq && gk != 1) losses = (losses + 1 > MAX_WAIT) ? MAX_WAIT : losses + 1;
      else                losses = 0;
      if (f == 2'd3) exp_err = 1'b1;
      prev_kind = e_re ? gk : 0;
      prev_data = ref_mem[e_addr];
      if (e_we) ref_mem[la] = wd;
      last_if_stall = e_ifst;
    end
  endtask

  initial begin
    bit         stall_at3;
    logic       rq;
    logic [7:0] ra;
    logic [1:0] rf;
    int         sel;

    rst = 1'b1; if_req = 1'b0; if_addr = 8'h00; ls_func = 2'b00;
    ls_addr = 8'h00; ls_wdata = 8'h00; pl_en = 1'b1; pl_addr = 8'h00; pl_dat = 8'h00;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'($urandom);
      if (i < 4)     ref_mem[i] = 8'(8'hA0 + i);
      if (i == 8'h20) ref_mem[i] = 8'h5C;
      @(negedge clk);
      pl_addr = 8'(i); pl_dat = ref_mem[i];
    end
    @(negedge clk);
    pl_en = 1'b0;
    @(posedge clk);

    // Reset state with requests present
    step(1, 1, 8'h07, 2'd1, 8'h08, 8'h00);
    check("rst_err", 32'(err), 32'd0);

    // Fetch only, addresses 0..3
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'(i), 2'd0, 8'h00, 8'h00);
      check("fetch_stall", 32'(if_stall), 32'd0);
      if (i > 0) check("fetch_rdata", 32'(if_rdata), 32'(8'hA0 + i - 1));
    end
    step(0, 0, 8'h00, 2'd0, 8'h00, 8'h00);
    check("fetch_last_rdata", 32'(if_rdata), 32'hA3);

    // Conflict: LSU read wins, fetch follows
    step(0, 1, 8'h10, 2'd1, 8'h20, 8'h00);
    check("confl_addr", 32'(mem_addr), 32'h20);
    check("confl_ifstall", 32'(if_stall), 32'd1);
    step(0, 1, 8'h10, 2'd0, 8'h00, 8'h00);
    check("confl_lsvalid", 32'(ls_valid), 32'd1);
    check("confl_rdata", 32'(ls_rdata), 32'h5C);
    check("confl_fetch_addr", 32'(mem_addr), 32'h10);

    // Starvation: six LSU writes against a held fetch
    wr_count = 0; stall_at3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 8'h50, 2'd2, 8'(8'h40 + i), 8'($urandom));
      if (i == 3) stall_at3 = ls_stall;
    end
    check("starve_writes", 32'(wr_count), 32'd5);
    check("starve_lsstall3", 32'(stall_at3), 32'd1);
    step(0, 0, 8'h00, 2'd0, 8'h00, 8'h00);

    // Write then read back
    step(0, 0, 8'h00, 2'd2, 8'h33, 8'h7E);
    check("wr_we", 32'(mem_we), 32'd1);
    step(0, 0, 8'h00, 2'd1, 8'h33, 8'h00);
    check("wr_no_valid", 32'(ls_valid), 32'd0);
    step(0, 0, 8'h00, 2'd0, 8'h00, 8'h00);
    check("rd_after_wr", 32'(ls_rdata), 32'h7E);

    // Reset mid-read
    step(0, 0, 8'h00, 2'd1, 8'h20, 8'h00);
    step(1, 1, 8'h01, 2'd2, 8'h21, 8'h11);
    check("rstmid_lsvalid", 32'(ls_valid), 32'd0);
    step(0, 0, 8'h00, 2'd0, 8'h00, 8'h00);
    check("rstmid_after", 32'(ls_valid), 32'd0);

    // Illegal op: sticky error
    step(0, 0, 8'h00, 2'd3, 8'h44, 8'h00);
    check("ill_stall", 32'(ls_stall), 32'd0);
    step(0, 0, 8'h00, 2'd0, 8'h00, 8'h00);
    check("ill_err", 32'(err), 32'd1);
    step(0, 1, 8'h02, 2'd0, 8'h00, 8'h00);
    step(1, 0, 8'h00, 2'd0, 8'h00, 8'h00);
    step(0, 0, 8'h00, 2'd0, 8'h00, 8'h00);
    check("ill_err_clr", 32'(err), 32'd0);

    // Random traffic; a stalled fetch keeps its request and address
    rq = 1'b0; ra = 8'h00;
    for (int n = 0; n < 400; n++) begin
      if (!last_if_stall) begin
        rq = ($urandom_range(0, 3) != 0);
        ra = 8'($urandom);
      end
      sel = $urandom_range(0, 19);
      rf = (sel < 6) ? 2'd0 : (sel < 12) ? 2'd1 : (sel < 19) ? 2'd2 : 2'd3;
      step(($urandom_range(0, 59) == 0), rq, ra, rf, 8'($urandom), 8'($urandom));
    end
    step(0, 0, 8'h00, 2'd0, 8'h00, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
